// File: rtl/pio_pkg.sv
// Shared declarations for the PIO command interface: bus widths, rw encoding
// and the target-side read FSM states.
package pio_pkg;

    localparam int PIO_ADDR_W = 16;
    localparam int PIO_DATA_W = 32;

    localparam logic PIO_RW_WRITE = 1'b1;
    localparam logic PIO_RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } pio_tgt_state_e;

endpackage

// File: rtl/pio_rd_sequencer.sv
// Read-response sequencer: times each accepted read out to a single rd_fire
// strobe RD_LATENCY cycles later and flags commands that arrive while busy.
module pio_rd_sequencer
    import pio_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_vld_i,
    input  logic rw_i,
    output logic cmd_accept_o,
    output logic rd_fire_o,
    output logic busy_o,
    output logic err_overrun_o
);

    localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

    pio_tgt_state_e state_q;
    logic [3:0]     cnt_q;
    logic [3:0]     cnt_d;
    logic           busy_q;
    logic           fire_q;
    logic           err_q;

    assign cnt_d        = cnt_q - 4'd1;
    assign cmd_accept_o = cmd_vld_i && (state_q == IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            fire_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            if (cmd_vld_i && (state_q != IDLE)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_vld_i && (rw_i == PIO_RW_READ)) begin
                        if (RD_LATENCY == 1) begin
                            state_q <= RESP;
                            fire_q  <= 1'b1;
                        end else begin
                            state_q <= RD_WAIT;
                            cnt_q   <= CNT_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    // Leave as the counter reaches zero so RESP lands exactly
                    // RD_LATENCY cycles after the command.
                    cnt_q <= cnt_d;
                    if (cnt_d == 4'd0) begin
                        state_q <= RESP;
                        busy_q  <= 1'b0;
                        fire_q  <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_fire_o     = fire_q;
    assign busy_o        = busy_q;
    assign err_overrun_o = err_q;

endmodule

// File: rtl/pio_target_regs.sv
// PIO target: decodes commands into a bank of 32-bit registers and returns
// read data after a fixed latency through pio_rd_sequencer.
module pio_target_regs
    import pio_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          RD_LATENCY = 2,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_vld,
    input  logic [PIO_ADDR_W-1:0]    addr,
    input  logic                     rw,
    input  logic [PIO_DATA_W-1:0]    data_w,
    output logic [PIO_DATA_W-1:0]    data_r,
    output logic                     rd_vld,
    output logic                     busy,
    output logic                     err_overrun,
    output logic [NUM_REGS*32-1:0]   regs_q
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("pio_target_regs: NUM_REGS must be 1..256");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $error("pio_target_regs: RD_LATENCY must be 1..15");
    end
    if (int'(BASE_ADDR) + NUM_REGS > 65536) begin : g_bad_range
        $error("pio_target_regs: register window overflows 16'hFFFF");
    end

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [PIO_ADDR_W-1:0] offset;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      rd_idx_q;
    logic                  rd_hit_q;
    logic                  cmd_accept;
    logic                  rd_fire;
    logic [PIO_DATA_W-1:0] reg_mem_q [NUM_REGS];

    assign offset = addr - BASE_ADDR;
    assign hit    = (addr >= BASE_ADDR) && (int'(offset) < NUM_REGS);
    assign idx    = offset[IDX_W-1:0];

    pio_rd_sequencer #(
        .RD_LATENCY (RD_LATENCY)
    ) u_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_vld_i     (cmd_vld),
        .rw_i          (rw),
        .cmd_accept_o  (cmd_accept),
        .rd_fire_o     (rd_fire),
        .busy_o        (busy),
        .err_overrun_o (err_overrun)
    );

    // NOTE: the register bank is cleared on reset because its contents are
    // architecturally visible on regs_q; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_mem_q[i] <= '0;
            end
            rd_idx_q <= '0;
            rd_hit_q <= 1'b0;
        end else if (cmd_accept) begin
            if (rw == PIO_RW_WRITE) begin
                if (hit) begin
                    reg_mem_q[idx] <= data_w;
                end
            end else begin
                rd_idx_q <= idx;
                rd_hit_q <= hit;
            end
        end
    end

    // NOTE: data_r gets a default before the conditional so no latch is inferred.
    always_comb begin
        data_r = '0;
        if (rd_fire) begin
            data_r = rd_hit_q ? reg_mem_q[rd_idx_q] : ERR_DATA;
        end
    end

    assign rd_vld = rd_fire;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_q[i*32 +: 32] = reg_mem_q[i];
    end

    a_cmd_vld_known: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_vld === 1'b1) || (cmd_vld === 1'b0));

endmodule

// File: tb/tb_pio_target_regs.sv
// Bench for pio_target_regs: directed cases with literal expectations plus a
// randomized phase checked every cycle against a cycle-count based model.
module tb_pio_target_regs;

    localparam logic [15:0] BASE = 16'h0100;
    localparam int          NREG = 16;
    localparam int          LAT  = 2;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        cmd_vld = 1'b0;
    logic [15:0] addr    = '0;
    logic        rw      = 1'b0;
    logic [31:0] data_w  = '0;
    logic [31:0] data_r;
    logic        rd_vld, busy, err_overrun;
    logic [NREG*32-1:0] regs_q;

    logic        s_vld  = 1'b0;
    logic [15:0] s_addr = '0;
    logic        s_rw   = 1'b0;
    logic [31:0] s_data = '0;
    logic [31:0] l1_data, l15_data;
    logic        l1_vld, l15_vld, l1_busy, l15_busy, l1_err, l15_err;
    logic [NREG*32-1:0] l1_regs, l15_regs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_target_regs #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .RD_LATENCY(LAT), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .addr(addr), .rw(rw), .data_w(data_w),
        .data_r(data_r), .rd_vld(rd_vld), .busy(busy), .err_overrun(err_overrun), .regs_q(regs_q));

    pio_target_regs #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .RD_LATENCY(1), .ERR_DATA(ERR)) u_l1 (
        .clk(clk), .reset(reset), .cmd_vld(s_vld), .addr(s_addr), .rw(s_rw), .data_w(s_data),
        .data_r(l1_data), .rd_vld(l1_vld), .busy(l1_busy), .err_overrun(l1_err), .regs_q(l1_regs));

    pio_target_regs #(.NUM_REGS(NREG), .BASE_ADDR(BASE), .RD_LATENCY(15), .ERR_DATA(ERR)) u_l15 (
        .clk(clk), .reset(reset), .cmd_vld(s_vld), .addr(s_addr), .rw(s_rw), .data_w(s_data),
        .data_r(l15_data), .rd_vld(l15_vld), .busy(l15_busy), .err_overrun(l15_err), .regs_q(l15_regs));

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register array, sticky error flag and the cycle number
    // of the last accepted read. The target is non-idle for the LAT cycles
    // that follow a read command.
    logic [31:0] m_regs [NREG];
    bit          m_err  = 1'b0;
    bit          m_pend = 1'b0;
    int          m_rd_cyc = 0;
    logic [15:0] m_rd_addr = '0;
    int          cyc = 0;
    bit          cmp_en = 1'b0;

    function automatic bit in_range(input logic [15:0] a);
        return (a >= BASE) && (a < BASE + 16'(NREG));
    endfunction

    function automatic logic [511:0] m_flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < NREG; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_err  = 1'b0;
            m_pend = 1'b0;
        end else if (cmd_vld) begin
            if (m_pend && (cyc > m_rd_cyc) && (cyc <= m_rd_cyc + LAT)) begin
                m_err = 1'b1;
            end else if (rw) begin
                if (in_range(addr)) m_regs[4'(addr - BASE)] = data_w;
            end else begin
                m_pend    = 1'b1;
                m_rd_cyc  = cyc;
                m_rd_addr = addr;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit          ev, eb;
        logic [31:0] ed;
        if (cmp_en) begin
            ev = m_pend && (cyc == m_rd_cyc + LAT);
            eb = m_pend && (cyc > m_rd_cyc) && (cyc < m_rd_cyc + LAT);
            ed = '0;
            if (ev) ed = in_range(m_rd_addr) ? m_regs[4'(m_rd_addr - BASE)] : ERR;
            check("model_rd_vld", 512'(rd_vld), 512'(ev));
            check("model_busy", 512'(busy), 512'(eb));
            check("model_data_r", 512'(data_r), 512'(ed));
            check("model_err_overrun", 512'(err_overrun), 512'(m_err));
            check("model_regs_q", 512'(regs_q), m_flat());
        end
    end

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit v, input bit w, input logic [15:0] a, input logic [31:0] d);
        cmd_vld = v; rw = w; addr = a; data_w = d;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic sdrive(input bit w, input logic [15:0] a, input logic [31:0] d);
        s_vld = 1'b1; s_rw = w; s_addr = a; s_data = d;
        @(posedge clk);
        #1;
        s_vld = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        nop(3);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_regs", 512'(regs_q), 512'd0);
        check("reset_busy_err_vld", 512'({busy, err_overrun, rd_vld}), 512'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nop(3);

        // Latency sweep on the RD_LATENCY = 1 and 15 instances.
        sdrive(1'b1, 16'h0100, 32'h1357_9BDF);
        sdrive(1'b0, 16'h0100, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("l1_rd_vld", 512'(l1_vld), 512'(k == 1));
            check("l1_data_r", 512'(l1_data), 512'((k == 1) ? 32'h1357_9BDF : 32'h0));
            check("l1_busy", 512'(l1_busy), 512'd0);
            check("l15_rd_vld", 512'(l15_vld), 512'(k == 15));
            check("l15_data_r", 512'(l15_data), 512'((k == 15) ? 32'h1357_9BDF : 32'h0));
            check("l15_busy", 512'(l15_busy), 512'(k <= 14));
            @(posedge clk);
            #1;
        end

        // Write then read back.
        drive(1'b1, 1'b1, 16'h0103, 32'hCAFE_0001);
        drive(1'b1, 1'b0, 16'h0103, 32'h0);
        nop(1);
        @(negedge clk);
        check("wr_rd_vld", 512'(rd_vld), 512'd1);
        check("wr_rd_data", 512'(data_r), 512'(32'hCAFE_0001));
        check("wr_rd_reg3", 512'(regs_q[3*32 +: 32]), 512'(32'hCAFE_0001));
        @(posedge clk);
        #1;

        // Out-of-range write is ignored, read returns the error pattern.
        drive(1'b1, 1'b1, 16'h0110, 32'h1234_5678);
        @(negedge clk);
        check("oor_regs", 512'(regs_q), 512'(32'hCAFE_0001) << 96);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'h0110, 32'h0);
        nop(1);
        @(negedge clk);
        check("oor_rd_vld", 512'(rd_vld), 512'd1);
        check("oor_rd_data", 512'(data_r), 512'(32'hDEAD_BEEF));
        @(posedge clk);
        #1;

        // Overrun: write issued the cycle after a read is dropped.
        drive(1'b1, 1'b1, 16'h0100, 32'h0000_AAAA);
        drive(1'b1, 1'b0, 16'h0100, 32'h0);
        drive(1'b1, 1'b1, 16'h0100, 32'h0000_BBBB);
        @(negedge clk);
        check("ovr_rd_vld", 512'(rd_vld), 512'd1);
        check("ovr_rd_data", 512'(data_r), 512'(32'h0000_AAAA));
        check("ovr_err", 512'(err_overrun), 512'd1);
        @(posedge clk);
        #1;
        nop(4);
        @(negedge clk);
        check("ovr_err_sticky", 512'(err_overrun), 512'd1);
        check("ovr_reg0", 512'(regs_q[31:0]), 512'(32'h0000_AAAA));
        @(posedge clk);
        #1;

        // Back-to-back writes, then a full readback at minimum spacing.
        for (int i = 0; i < NREG; i++) drive(1'b1, 1'b1, BASE + 16'(i), 32'(i) * 32'h11);
        for (int i = 0; i < NREG; i++) begin
            drive(1'b1, 1'b0, BASE + 16'(i), 32'h0);
            nop(1);
            @(negedge clk);
            check("b2b_readback", 512'({rd_vld, data_r}), 512'({1'b1, 32'(i) * 32'h11}));
            @(posedge clk);
            #1;
        end

        // Reset pulse while a read waits: the response is abandoned.
        drive(1'b1, 1'b0, 16'h0105, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_regs", 512'(regs_q), 512'd0);
        check("midrst_busy_err", 512'({busy, err_overrun}), 512'd0);
        repeat (20) begin
            @(negedge clk);
            check("midrst_no_rd_vld", 512'(rd_vld), 512'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic, including commands while busy and random resets.
        for (int n = 0; n < 3000; n++) begin
            bit          v;
            logic [15:0] a;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 99) < 45);
                a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(16'h00F8, 16'h0117));
                drive(v, 1'($urandom), a, $urandom);
            end
        end

        nop(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
